// File: rtl/shift_pkg.sv
// Shared definitions for the bidirectional deserializer slice:
// shift direction encodings and the receive FSM state type.
package shift_pkg;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic {
        IDLE,
        COLLECT
    } deser_state_t;

endpackage

// File: rtl/bidir_deserializer_if.sv
// Serial input side and parallel valid/ready output side of the deserializer,
// with status outputs. The slave modport is the deserializer's view.
interface bidir_deserializer_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             sin;
    logic             sin_valid;
    logic             dir;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;

    modport master (
        output sin, sin_valid, dir, dout_ready,
        input  dout, dout_valid, busy, bit_cnt, overrun
    );

    modport slave (
        input  sin, sin_valid, dir, dout_ready,
        output dout, dout_valid, busy, bit_cnt, overrun
    );

endinterface

// File: rtl/bidir_shift_core.sv
// Shift register, per-word direction latch and bit counter. Presents the word
// including the bit being accepted, plus a done strobe on the final bit.
module bidir_shift_core
    import shift_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             dir,
    output logic [WIDTH-1:0] word,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    logic [WIDTH-1:0] shreg;
    logic             dir_q;
    logic             eff_dir;
    logic             accept;

    // Live dir only matters on the first bit; afterwards the latched copy rules.
    always_comb begin
        accept  = sin_valid && !clear;
        eff_dir = (bit_cnt == '0) ? dir : dir_q;
        word    = (eff_dir == DIR_MSB_FIRST) ? {shreg[WIDTH-2:0], sin}
                                             : {sin, shreg[WIDTH-1:1]};
        done    = accept && (bit_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            dir_q   <= DIR_MSB_FIRST;
        end else if (clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
            dir_q   <= DIR_MSB_FIRST;
        end else if (accept) begin
            dir_q <= eff_dir;
            if (done) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else begin
                shreg   <= word;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bidir_deserializer.sv
// Serial-in/parallel-out receiver: collects WIDTH-bit words MSB- or LSB-first
// and hands them to a valid/ready consumer, flagging words lost to overrun.
module bidir_deserializer
    import shift_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    bidir_deserializer_if.slave bus
);

    deser_state_t     state;
    logic [WIDTH-1:0] word;
    logic             done;
    logic             slot_free;
    logic             consume;

    bidir_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .sin       (bus.sin),
        .sin_valid (bus.sin_valid),
        .dir       (bus.dir),
        .word      (word),
        .done      (done),
        .bit_cnt   (bus.bit_cnt)
    );

    // A slot being consumed this cycle can take a new word on the same edge.
    assign consume   = bus.dout_valid && bus.dout_ready;
    assign slot_free = !bus.dout_valid || bus.dout_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.overrun    <= 1'b0;
        end else if (clear) begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.dout_valid <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.sin_valid) begin
                        state    <= COLLECT;
                        bus.busy <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (done) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase

            if (done && slot_free) begin
                bus.dout       <= word;
                bus.dout_valid <= 1'b1;
            end else begin
                if (done) begin
                    bus.overrun <= 1'b1;
                end
                if (consume) begin
                    bus.dout_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bidir_deserializer.sv
// Self-checking bench for bidir_deserializer: directed scenarios plus random
// traffic, compared against a word-level queue model of the receiver.
module tb_bidir_deserializer;
    import shift_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic rst;
    logic clear;

    bidir_deserializer_if #(.WIDTH(WIDTH)) bus ();

    bidir_deserializer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vector_count    = 0;
    int miscompare_count = 0;

    // Reference model: bits of the word in arrival order, plus the output slot.
    logic             model_bits[$];
    logic             model_dir;
    logic [WIDTH-1:0] exp_dout;
    logic             exp_valid;
    logic             exp_overrun;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        model_bits.delete();
        model_dir   = DIR_MSB_FIRST;
        exp_dout    = '0;
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] assembleWord();
        logic [WIDTH-1:0] w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (model_dir == DIR_MSB_FIRST) w[WIDTH-1-i] = model_bits[i];
            else                            w[i]         = model_bits[i];
        end
        return w;
    endfunction

    task automatic modelStep(input logic s, input logic sv, input logic d,
                             input logic rdy, input logic clr);
        logic             done = 1'b0;
        logic [WIDTH-1:0] w    = '0;
        if (clr) begin
            model_bits.delete();
            exp_valid   = 1'b0;
            exp_overrun = 1'b0;
            return;
        end
        if (sv) begin
            if (model_bits.size() == 0) model_dir = d;
            model_bits.push_back(s);
            if (model_bits.size() == WIDTH) begin
                w    = assembleWord();
                done = 1'b1;
                model_bits.delete();
            end
        end
        if (done) begin
            if (!exp_valid || rdy) begin
                exp_dout  = w;
                exp_valid = 1'b1;
            end else begin
                exp_overrun = 1'b1;
            end
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_dout"},    32'(bus.dout),       32'(exp_dout));
        checkOutput({tag, "_valid"},   32'(bus.dout_valid), 32'(exp_valid));
        checkOutput({tag, "_overrun"}, 32'(bus.overrun),    32'(exp_overrun));
        checkOutput({tag, "_busy"},    32'(bus.busy),       32'(model_bits.size() != 0));
        checkOutput({tag, "_bitcnt"},  32'(bus.bit_cnt),    32'(model_bits.size()));
    endtask

    task automatic applyStimulus(input logic s, input logic sv, input logic d,
                                 input logic rdy, input logic clr, input string tag);
        bus.sin        = s;
        bus.sin_valid  = sv;
        bus.dir        = d;
        bus.dout_ready = rdy;
        clear          = clr;
        @(posedge clk);
        modelStep(s, sv, d, rdy, clr);
        #1;
        checkAll(tag);
    endtask

    // Bits go out from pat[WIDTH-1] down to pat[0]; ready applies to every bit.
    task automatic sendWord(input logic [WIDTH-1:0] pat, input logic d,
                            input logic rdy, input string tag);
        for (int i = WIDTH - 1; i >= 0; i--) applyStimulus(pat[i], 1'b1, d, rdy, 1'b0, tag);
    endtask

    // Reset asserted between clock edges, held for two edges, released mid-cycle.
    task automatic applyReset();
        bus.sin_valid = 1'b0;
        clear         = 1'b0;
        rst           = 1'b0;
        #2;
        modelReset();
        checkAll("reset");
        checkOutput("reset_dout_zero", 32'(bus.dout), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset_hold");
        rst = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] pat;
        rst            = 1'b0;
        clear          = 1'b0;
        bus.sin        = 1'b0;
        bus.sin_valid  = 1'b0;
        bus.dir        = DIR_MSB_FIRST;
        bus.dout_ready = 1'b1;
        #1;
        applyReset();

        $display("[TB] MSB-first word");
        sendWord(4'b1101, DIR_MSB_FIRST, 1'b1, "msb");
        checkOutput("msb_word", 32'(bus.dout), 32'h0000_000D);
        checkOutput("msb_valid", 32'(bus.dout_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "msb_idle");
        checkOutput("msb_pulse_end", 32'(bus.dout_valid), 32'd0);

        $display("[TB] LSB-first word with dir toggled mid-word");
        pat = 4'b1101;
        for (int i = WIDTH - 1; i >= 0; i--)
            applyStimulus(pat[i], 1'b1, (i >= 2) ? DIR_LSB_FIRST : DIR_MSB_FIRST,
                          1'b1, 1'b0, "lsb");
        checkOutput("lsb_word", 32'(bus.dout), 32'h0000_000B);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "lsb_idle");

        $display("[TB] overrun then clear");
        sendWord(4'b1001, DIR_MSB_FIRST, 1'b0, "ovr_a");
        sendWord(4'b0110, DIR_MSB_FIRST, 1'b0, "ovr_b");
        checkOutput("ovr_dout_kept", 32'(bus.dout), 32'h0000_0009);
        checkOutput("ovr_flag", 32'(bus.overrun), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "ovr_clear");
        checkOutput("clear_overrun", 32'(bus.overrun), 32'd0);
        checkOutput("clear_dout_hold", 32'(bus.dout), 32'h0000_0009);

        $display("[TB] consume and complete on the same cycle");
        sendWord(4'b0011, DIR_MSB_FIRST, 1'b0, "swap_a");
        pat = 4'b1100;
        for (int i = WIDTH - 1; i >= 0; i--)
            applyStimulus(pat[i], 1'b1, DIR_MSB_FIRST, (i == 0), 1'b0, "swap_b");
        checkOutput("swap_word", 32'(bus.dout), 32'h0000_000C);
        checkOutput("swap_valid", 32'(bus.dout_valid), 32'd1);
        checkOutput("swap_no_overrun", 32'(bus.overrun), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "swap_idle");

        $display("[TB] gaps between bits");
        pat = 4'b0110;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            applyStimulus(pat[i], 1'b1, DIR_MSB_FIRST, 1'b1, 1'b0, "gap_bit");
            if (i == WIDTH - 1) checkOutput("gap_busy_first", 32'(bus.busy), 32'd1);
            for (int g = 0; g < (WIDTH - 1 - i) && i != 0; g++)
                applyStimulus(1'b1, 1'b0, DIR_LSB_FIRST, 1'b1, 1'b0, "gap_idle");
        end
        checkOutput("gap_word", 32'(bus.dout), 32'h0000_0006);
        checkOutput("gap_busy_done", 32'(bus.busy), 32'd0);

        $display("[TB] reset mid-word");
        applyStimulus(1'b1, 1'b1, DIR_MSB_FIRST, 1'b1, 1'b0, "rst_pre");
        applyStimulus(1'b0, 1'b1, DIR_MSB_FIRST, 1'b1, 1'b0, "rst_pre");
        applyReset();
        sendWord(4'b1010, DIR_MSB_FIRST, 1'b1, "rst_post");
        checkOutput("rst_post_word", 32'(bus.dout), 32'h0000_000A);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom), ($urandom_range(3) != 0), 1'($urandom),
                          1'($urandom), ($urandom_range(31) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
